// File: rtl/keccak_arbiter_pkg.sv
// Shared types and constants for the two-requester keccak core arbiter.
// Optional feature macro: KECCAK_ARB_STATS_EN (per-requester job counters).
package keccak_arbiter_pkg;

    // Word widths of the keccak_top input and output streams
    localparam int WIN           = 64;
    localparam int WOUT          = 64;
    localparam int OUT_WORDS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ABSORB  = 2'd1,
        ST_SQUEEZE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/keccak_arbiter_rr_sel.sv
// Two-request round-robin selector: on a tie the requester that was not
// served last wins; a lone request always wins.
module keccak_arbiter_rr_sel (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] gnt
);

    // One-hot grant from the request pair and the last-served index
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_served ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/keccak_arbiter.sv
// Arbitrates one keccak core between two requesters. A job is a stream of
// input words ending with din_last, followed by exactly OUT_WORDS result
// words returned to the same requester. Ownership is held for the whole job.
// Optional feature macro: KECCAK_ARB_STATS_EN adds jobs_0 / jobs_1 counters.
module keccak_arbiter
    import keccak_arbiter_pkg::*;
#(
    parameter int OUT_WORDS = OUT_WORDS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            din_valid_0,
    input  logic            din_valid_1,
    output logic            din_ready_0,
    output logic            din_ready_1,
    input  logic [WIN-1:0]  din_0,
    input  logic [WIN-1:0]  din_1,
    input  logic            din_last_0,
    input  logic            din_last_1,
    output logic            dout_valid_0,
    output logic            dout_valid_1,
    input  logic            dout_ready_0,
    input  logic            dout_ready_1,
    output logic [WOUT-1:0] dout_0,
    output logic [WOUT-1:0] dout_1,
    output logic            core_din_valid,
    input  logic            core_din_ready,
    output logic [WIN-1:0]  core_din,
    input  logic            core_dout_valid,
    output logic            core_dout_ready,
    input  logic [WOUT-1:0] core_dout,
    output logic [1:0]      grant,
`ifdef KECCAK_ARB_STATS_EN
    output logic [15:0]     jobs_0,
    output logic [15:0]     jobs_1,
`endif
    output logic            busy
);

    localparam int CW = $clog2(OUT_WORDS + 1);

    arb_state_e    state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    rr_gnt;
    logic          sel;
    logic          in_xfer;
    logic          out_xfer;
    logic          job_done;

    keccak_arbiter_rr_sel u_rr_sel (
        .req         ({din_valid_1, din_valid_0}),
        .last_served (last_q),
        .gnt         (rr_gnt)
    );

    // Index of the owning requester (meaningful only while grant is set)
    assign sel   = grant_q[1];
    assign grant = grant_q;
    assign busy  = (state_q != ST_IDLE);

    // Result words fan out to both requesters; only dout_valid qualifies them
    assign dout_0 = core_dout;
    assign dout_1 = core_dout;

    // Next-state logic and datapath steering; everything idle by default
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_d          = last_q;
        cnt_d           = cnt_q;
        core_din_valid  = 1'b0;
        core_din        = '0;
        din_ready_0     = 1'b0;
        din_ready_1     = 1'b0;
        core_dout_ready = 1'b0;
        dout_valid_0    = 1'b0;
        dout_valid_1    = 1'b0;
        in_xfer         = 1'b0;
        out_xfer        = 1'b0;
        job_done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Grant is registered first; data moves from the next cycle
                if (din_valid_0 || din_valid_1) begin
                    grant_d = rr_gnt;
                    state_d = ST_ABSORB;
                end
            end
            ST_ABSORB: begin
                core_din       = sel ? din_1 : din_0;
                core_din_valid = sel ? din_valid_1 : din_valid_0;
                din_ready_0    = grant_q[0] & core_din_ready;
                din_ready_1    = grant_q[1] & core_din_ready;
                in_xfer        = core_din_valid & core_din_ready;
                if (in_xfer && (sel ? din_last_1 : din_last_0)) begin
                    state_d = ST_SQUEEZE;
                    cnt_d   = '0;
                end
            end
            ST_SQUEEZE: begin
                dout_valid_0    = grant_q[0] & core_dout_valid;
                dout_valid_1    = grant_q[1] & core_dout_valid;
                core_dout_ready = sel ? dout_ready_1 : dout_ready_0;
                out_xfer        = core_dout_valid & core_dout_ready;
                if (out_xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(OUT_WORDS - 1)) begin
                        job_done = 1'b1;
                        state_d  = ST_IDLE;
                        grant_d  = 2'b00;
                        last_d   = sel;
                        cnt_d    = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // State registers; reset leaves requester 1 as last served so 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef KECCAK_ARB_STATS_EN
    logic [15:0] jobs_0_q, jobs_0_d, jobs_1_q, jobs_1_d;

    // Completed-job counters, saturating at all-ones
    always_comb begin
        jobs_0_d = jobs_0_q;
        jobs_1_d = jobs_1_q;
        if (job_done && !sel && jobs_0_q != 16'hFFFF) jobs_0_d = jobs_0_q + 16'd1;
        if (job_done &&  sel && jobs_1_q != 16'hFFFF) jobs_1_d = jobs_1_q + 16'd1;
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jobs_0_q <= '0;
            jobs_1_q <= '0;
        end else begin
            jobs_0_q <= jobs_0_d;
            jobs_1_q <= jobs_1_d;
        end
    end

    assign jobs_0 = jobs_0_q;
    assign jobs_1 = jobs_1_q;
`endif

endmodule

// File: tb/tb_keccak_arbiter.sv
// Self-checking bench for keccak_arbiter: a job-level reference model is
// compared against the DUT every cycle, plus directed scenarios with
// hand-computed expectations and a second instance built with OUT_WORDS=1.
module tb_keccak_arbiter;
    import keccak_arbiter_pkg::*;

    localparam int OW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            din_valid_0 = 0, din_valid_1 = 0;
    logic            din_last_0 = 0, din_last_1 = 0;
    logic [WIN-1:0]  din_0 = '0, din_1 = '0;
    logic            dout_ready_0 = 0, dout_ready_1 = 0;
    logic            core_din_ready = 0, core_dout_valid = 0;
    logic [WOUT-1:0] core_dout = '0;

    logic            din_ready_0, din_ready_1, dout_valid_0, dout_valid_1;
    logic [WOUT-1:0] dout_0, dout_1;
    logic            core_din_valid, core_dout_ready, busy;
    logic [WIN-1:0]  core_din;
    logic [1:0]      grant;

    logic            b_din_ready_0, b_din_ready_1, b_dout_valid_0, b_dout_valid_1;
    logic [WOUT-1:0] b_dout_0, b_dout_1;
    logic            b_core_din_valid, b_core_dout_ready, b_busy;
    logic [WIN-1:0]  b_core_din;
    logic [1:0]      b_grant;
`ifdef KECCAK_ARB_STATS_EN
    logic [15:0]     jobs_0, jobs_1, b_jobs_0, b_jobs_1;
`endif

    int checks = 0;
    int passes = 0;
    bit run_chk = 0;

    always #5 clk = ~clk;

    keccak_arbiter #(.OUT_WORDS(OW)) u_dut (
        .clk(clk), .rst(rst),
        .din_valid_0(din_valid_0), .din_valid_1(din_valid_1),
        .din_ready_0(din_ready_0), .din_ready_1(din_ready_1),
        .din_0(din_0), .din_1(din_1),
        .din_last_0(din_last_0), .din_last_1(din_last_1),
        .dout_valid_0(dout_valid_0), .dout_valid_1(dout_valid_1),
        .dout_ready_0(dout_ready_0), .dout_ready_1(dout_ready_1),
        .dout_0(dout_0), .dout_1(dout_1),
        .core_din_valid(core_din_valid), .core_din_ready(core_din_ready),
        .core_din(core_din),
        .core_dout_valid(core_dout_valid), .core_dout_ready(core_dout_ready),
        .core_dout(core_dout),
        .grant(grant),
`ifdef KECCAK_ARB_STATS_EN
        .jobs_0(jobs_0), .jobs_1(jobs_1),
`endif
        .busy(busy)
    );

    keccak_arbiter #(.OUT_WORDS(1)) u_one (
        .clk(clk), .rst(rst),
        .din_valid_0(din_valid_0), .din_valid_1(din_valid_1),
        .din_ready_0(b_din_ready_0), .din_ready_1(b_din_ready_1),
        .din_0(din_0), .din_1(din_1),
        .din_last_0(din_last_0), .din_last_1(din_last_1),
        .dout_valid_0(b_dout_valid_0), .dout_valid_1(b_dout_valid_1),
        .dout_ready_0(dout_ready_0), .dout_ready_1(dout_ready_1),
        .dout_0(b_dout_0), .dout_1(b_dout_1),
        .core_din_valid(b_core_din_valid), .core_din_ready(core_din_ready),
        .core_din(b_core_din),
        .core_dout_valid(core_dout_valid), .core_dout_ready(b_core_dout_ready),
        .core_dout(core_dout),
        .grant(b_grant),
`ifdef KECCAK_ARB_STATS_EN
        .jobs_0(b_jobs_0), .jobs_1(b_jobs_1),
`endif
        .busy(b_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: owner (-1 = none), absorbing flag, words left to return
    int m_owner = -1;
    int m_last  = 1;
    int m_left  = 0;
    bit m_absorb = 0;
    int served[$];
    int jobs_m[2];
    int in_xfer[2];
    int out_xfer[2];
    int dv_seen[2];

    always @(negedge clk) begin : model
        logic [1:0] dv, dr, dl, eg, edr, edv;
        logic       ecdv, ecdr;
        if (run_chk) begin
            dv = {din_valid_1, din_valid_0};
            dr = {dout_ready_1, dout_ready_0};
            dl = {din_last_1, din_last_0};
            if (rst) begin
                chk("rst_grant", grant, 2'b00);
                chk("rst_busy", busy, 1'b0);
                chk("rst_outs", {core_din_valid, core_dout_ready, din_ready_1, din_ready_0,
                                 dout_valid_1, dout_valid_0}, 6'd0);
                m_owner = -1; m_last = 1; m_absorb = 0;
            end else begin
                eg = (m_owner == 0) ? 2'b01 : ((m_owner == 1) ? 2'b10 : 2'b00);
                ecdv = 0; ecdr = 0; edr = 2'b00; edv = 2'b00;
                if (m_owner >= 0 && m_absorb) begin
                    ecdv = dv[m_owner];
                    edr  = core_din_ready ? eg : 2'b00;
                end
                if (m_owner >= 0 && !m_absorb) begin
                    ecdr = dr[m_owner];
                    edv  = core_dout_valid ? eg : 2'b00;
                end
                chk("grant", grant, eg);
                chk("busy", busy, m_owner >= 0);
                chk("core_din_valid", core_din_valid, ecdv);
                if (ecdv) chk("core_din", core_din, (m_owner == 1) ? din_1 : din_0);
                chk("din_ready", {din_ready_1, din_ready_0}, edr);
                chk("core_dout_ready", core_dout_ready, ecdr);
                chk("dout_valid", {dout_valid_1, dout_valid_0}, edv);
                chk("dout_data", {dout_1 ^ core_dout, dout_0 ^ core_dout}, '0);
                // handshake monitor used by the directed scenarios
                in_xfer[0]  += int'(din_valid_0 & din_ready_0);
                in_xfer[1]  += int'(din_valid_1 & din_ready_1);
                out_xfer[0] += int'(dout_valid_0 & dout_ready_0);
                out_xfer[1] += int'(dout_valid_1 & dout_ready_1);
                dv_seen[0]  += int'(dout_valid_0);
                dv_seen[1]  += int'(dout_valid_1);
                // advance the model across the coming rising edge
                if (m_owner < 0) begin
                    if (dv != 2'b00) begin
                        m_owner  = (dv == 2'b11) ? (1 - m_last) : (dv[0] ? 0 : 1);
                        m_absorb = 1;
                    end
                end else if (m_absorb) begin
                    if (dv[m_owner] && core_din_ready && dl[m_owner]) begin
                        m_absorb = 0;
                        m_left   = OW;
                    end
                end else if (core_dout_valid && dr[m_owner]) begin
                    m_left--;
                    if (m_left == 0) begin
                        served.push_back(m_owner);
                        jobs_m[m_owner]++;
                        m_last  = m_owner;
                        m_owner = -1;
                    end
                end
            end
        end
    end

    task automatic drive_idle();
        din_valid_0 = 0; din_valid_1 = 0; din_last_0 = 0; din_last_1 = 0;
        dout_ready_0 = 0; dout_ready_1 = 0; core_din_ready = 0; core_dout_valid = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drive_idle();
        rst = 1;
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_grant", grant, 2'b00);
        @(posedge clk); #1;
        rst = 0;
    endtask

    // One job on requester r: nw input words, back-pressure toggling optional,
    // optional reset pulse on output transfer index rst_at
    task automatic job(input int r, input int nw, input bit toggle, input int rst_at,
                       output int got_in, output int got_out);
        int b_in, b_out, b_srv, cyc, k;
        bit hit;
        b_in = in_xfer[r]; b_out = out_xfer[r]; b_srv = served.size();
        cyc = 0; hit = 0;
        while (served.size() == b_srv && cyc < 400 && !hit) begin
            @(posedge clk); #1;
            cyc++;
            k = in_xfer[r] - b_in;
            core_din_ready  = 1;
            core_dout_valid = 1;
            core_dout       = {$urandom, $urandom};
            if (r == 0) begin
                din_valid_0 = (k < nw); din_last_0 = (k == nw - 1); din_0 = {$urandom, $urandom};
                dout_ready_0 = toggle ? ~dout_ready_0 : 1'b1;
            end else begin
                din_valid_1 = (k < nw); din_last_1 = (k == nw - 1); din_1 = {$urandom, $urandom};
                dout_ready_1 = toggle ? ~dout_ready_1 : 1'b1;
            end
            if (rst_at >= 0 && (out_xfer[r] - b_out) == rst_at && busy) begin
                rst = 1;
                #1;
                chk("midrst_grant", grant, 2'b00);
                chk("midrst_busy", busy, 1'b0);
                chk("midrst_valids", {dout_valid_1, dout_valid_0, core_din_valid}, 3'd0);
                hit = 1;
            end
        end
        if (!hit && cyc >= 400) chk("job_timeout", 1'b1, 1'b0);
        got_in  = in_xfer[r] - b_in;
        got_out = out_xfer[r] - b_out;
        if (!hit) chk("job_end_grant", grant, 2'b00);
        @(posedge clk); #1;
        rst = 0;
        drive_idle();
    endtask

    initial begin : stim
        int gi, go, b_srv, b_dv1, cyc, n1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        run_chk = 1;
        do_reset();

        // single req0 job, 3 input words, 8 result words
        b_dv1 = dv_seen[1];
        job(0, 3, 0, -1, gi, go);
        chk("j0_in_words", 32'(gi), 32'd3);
        chk("j0_out_words", 32'(go), 32'd8);
        chk("j0_dv1_never", 32'(dv_seen[1] - b_dv1), 32'd0);

        // simultaneous requests after reset: 0, then 1, then 0
        do_reset();
        b_srv = served.size();
        din_valid_0 = 1; din_valid_1 = 1; din_last_0 = 1; din_last_1 = 1;
        core_din_ready = 1; core_dout_valid = 1; dout_ready_0 = 1; dout_ready_1 = 1;
        @(posedge clk); #1;
        chk("rr_first_grant", grant, 2'b01);
        cyc = 0;
        while (served.size() < b_srv + 3 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        drive_idle();
        if (served.size() < b_srv + 3) chk("rr_timeout", 1'b1, 1'b0);
        else begin
            chk("rr_order0", 32'(served[b_srv]), 32'd0);
            chk("rr_order1", 32'(served[b_srv + 1]), 32'd1);
            chk("rr_order2", 32'(served[b_srv + 2]), 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;

        // output back-pressure toggling every cycle
        job(0, 2, 1, -1, gi, go);
        chk("bp_out_words", 32'(go), 32'd8);

        // reset on the second output transfer, then a clean job
        job(0, 2, 0, 1, gi, go);
        chk("midrst_out_before", 32'(go), 32'd1);
        job(0, 2, 0, -1, gi, go);
        chk("after_rst_out_words", 32'(go), 32'd8);

        // OUT_WORDS=1 instance: req1 single word
        do_reset();
        din_valid_1 = 1; din_last_1 = 1; core_din_ready = 1; core_dout_valid = 1;
        dout_ready_1 = 1;
        #1;
        chk("one_idle_grant", b_grant, 2'b00);
        @(posedge clk); #1;
        chk("one_absorb_grant", b_grant, 2'b10);
        chk("one_din_ready", b_din_ready_1, 1'b1);
        @(posedge clk); #1;
        din_valid_1 = 0; din_last_1 = 0;
        chk("one_squeeze_valid", {b_dout_valid_1, b_dout_valid_0}, 2'b10);
        n1 = 0;
        if (b_dout_valid_1 && dout_ready_1) n1++;
        @(posedge clk); #1;
        chk("one_out_count", 32'(n1), 32'd1);
        chk("one_idle_busy", b_busy, 1'b0);
        chk("one_idle_grant2", b_grant, 2'b00);
        dout_ready_1 = 0;
        repeat (12) @(posedge clk);
        #1;
        drive_idle();

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            rst             = ($urandom_range(0, 499) == 0);
            din_valid_0     = ($urandom_range(0, 2) != 0);
            din_valid_1     = ($urandom_range(0, 2) != 0);
            din_last_0      = ($urandom_range(0, 3) == 0);
            din_last_1      = ($urandom_range(0, 3) == 0);
            din_0           = {$urandom, $urandom};
            din_1           = {$urandom, $urandom};
            core_din_ready  = ($urandom_range(0, 3) != 0);
            core_dout_valid = ($urandom_range(0, 3) != 0);
            core_dout       = {$urandom, $urandom};
            dout_ready_0    = $urandom_range(0, 1);
            dout_ready_1    = $urandom_range(0, 1);
        end
        @(posedge clk); #1;
        rst = 0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
`ifdef KECCAK_ARB_STATS_EN
        chk("jobs_0", jobs_0, 16'(jobs_m[0]));
        chk("jobs_1", jobs_1, 16'(jobs_m[1]));
`endif
        run_chk = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/keccak_arbiter.md
KECCAK_ARBITER -- requirements
Module: keccak_arbiter

Interface
REQ-001 Parameter OUT_WORDS, default 8, number of `WOUT-bit output words per job (legal range 1..65535).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 din_valid_0 / din_valid_1  input  1 each  requester input word valid.
REQ-005 din_ready_0 / din_ready_1  output  1 each  requester input word accepted.
REQ-006 din_0 / din_1  input  `WIN each  requester input words, in keccak_top input format.
REQ-007 din_last_0 / din_last_1  input  1 each  marks the final input word of a job.
REQ-008 dout_valid_0 / dout_valid_1  output  1 each  result word valid to requester.
REQ-009 dout_ready_0 / dout_ready_1  input  1 each  requester accepts result word.
REQ-010 dout_0 / dout_1  output  `WOUT each  result word, both driven from core_dout.
REQ-011 core_din_valid  output  1, core_din_ready  input  1, core_din  output  `WIN: to keccak_top input.
REQ-012 core_dout_valid  input  1, core_dout_ready  output  1, core_dout  input  `WOUT: from keccak_top output.
REQ-013 grant  output  2  one-hot owner of the core; 2'b00 when idle.
REQ-014 busy  output  1  high in ABSORB or SQUEEZE.

Function
REQ-015 FSM states IDLE, ABSORB, SQUEEZE; one job = input words through din_last, then exactly OUT_WORDS output words.
REQ-016 IDLE: grant = 00; no core or requester handshakes occur (all valid/ready outputs 0).
REQ-017 IDLE with any din_valid_x high: register grant, go to ABSORB next cycle; first data transfer no earlier than the cycle after.
REQ-018 Both requesters valid in IDLE: grant the requester not served last (round-robin, last_served register); after reset, requester 0 wins.
REQ-019 ABSORB: core_din = granted din, core_din_valid = granted din_valid, granted din_ready = core_din_ready, combinational; non-granted din_ready = 0.
REQ-020 ABSORB transfer (core_din_valid & core_din_ready) with granted din_last = 1: go to SQUEEZE, clear out_cnt.
REQ-021 Outside ABSORB core_din_valid = 0; outside SQUEEZE core_dout_ready = 0 and both dout_valid = 0.
REQ-022 SQUEEZE: granted dout_valid = core_dout_valid, core_dout_ready = granted dout_ready; non-granted dout_valid = 0.
REQ-023 Each SQUEEZE transfer increments out_cnt; transfer with out_cnt == OUT_WORDS-1 goes to IDLE, updates last_served, clears grant.
REQ-024 out_cnt width = clog2(OUT_WORDS+1); never wraps within a job; OUT_WORDS = 1 ends SQUEEZE on first transfer.
REQ-025 Requester dropping din_valid mid-ABSORB: grant held, no timeout; non-granted requests wait indefinitely while a job is active.
REQ-026 Core back-pressure (core_din_ready or dout_ready low) stalls only; no words dropped or duplicated.

Reset
REQ-027 rst asserted at any time, including mid-job: state = IDLE, grant = 00, busy = 0, out_cnt = 0, last_served = requester 1, all ready/valid outputs 0 immediately.
REQ-028 Arbiter does not reset keccak_top; the system asserts the same rst to both.

Configuration
REQ-029 Macro KECCAK_ARB_STATS_EN defined: add outputs jobs_0 / jobs_1 (16 bits each), incremented on the final SQUEEZE transfer of that requester's job, saturating at 16'hFFFF, reset to 0.
REQ-030 KECCAK_ARB_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-031 State encoding localparams and the OUT_WORDS default belong in keccak_pkg.v; counter width uses clog2.v.
REQ-032 One sub-module, keccak_rr_sel: two-request round-robin selector (inputs req[1:0], last_served; output one-hot gnt).

Verification
REQ-033 Single job on req0, 3 input words (last on 3rd), OUT_WORDS=8 -> 3 core_din transfers, 8 words on dout_0, dout_valid_1 never high, grant 01 then 00.
REQ-034 Both din_valid high after reset -> req0 job served first, req1 second, then req0 again on repeat.
REQ-035 dout_ready_0 toggled 1/0 each cycle during SQUEEZE -> exactly 8 transfers, words match core_dout sequence in order.
REQ-036 rst pulsed on 2nd SQUEEZE transfer -> same cycle grant = 00, busy = 0, all valids 0; next job completes normally.
REQ-037 OUT_WORDS=1, req1 single word with din_last -> one output transfer, return to IDLE next cycle.
REQ-038 With KECCAK_ARB_STATS_EN, 3 req0 jobs and 2 req1 jobs -> jobs_0 = 3, jobs_1 = 2.
